instruction_fetch: RTL and testbench

Program-counter and fetch-buffer stage that drives the read port of the synchronous single-cycle-latency instruction RAM and hands fetched words to decode through a valid/ready handshake. It owns the PC, tracks the one read in flight, and absorbs decode stalls in a 2-entry buffer so the RAM read latency never drops or duplicates an instruction. Branch/jump redirects from execute flush everything in flight.

---
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency RAM reads and
// buffers returned words in a 2-entry FIFO so decode stalls never drop or repeat one.
module instruction_fetch #(
    parameter int unsigned          dataWidth = 16,
    parameter int unsigned          addrWidth = 8,
    parameter logic [addrWidth-1:0] resetPC   = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [addrWidth-1:0] memAddress,
    input  logic [dataWidth-1:0] memData,
    output logic [dataWidth-1:0] instrOut,
    output logic [addrWidth-1:0] instrPC,
    output logic                 instrValid,
    input  logic                 instrReady,
    input  logic                 redirect,
    input  logic [addrWidth-1:0] redirectPC,
    input  logic                 halt
);

    typedef struct packed {
        logic [addrWidth-1:0] pc;
        logic [dataWidth-1:0] instr;
    } entry_t;

    logic [addrWidth-1:0] pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [addrWidth-1:0] inflight_pc_q, inflight_pc_d;
    entry_t               head_q, head_d, tail_q, tail_d;
    logic                 head_v_q, head_v_d, tail_v_q, tail_v_d;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [2:0]           occupancy;
    entry_t               new_entry;

    // Redirect squashes both the handshake and the returning word in the same cycle.
    assign pop       = head_v_q && instrReady && !redirect;
    assign push      = inflight_q && !redirect;
    assign occupancy = 3'(head_v_q) + 3'(tail_v_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = !redirect && !halt && (occupancy < 3'd2);
    assign new_entry = '{pc: inflight_pc_q, instr: memData};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        head_v_d      = head_v_q;
        tail_v_d      = tail_v_q;

        if (redirect) begin
            pc_d     = redirectPC;
            head_v_d = 1'b0;
            tail_v_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + addrWidth'(1);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end

            // Head/tail shuffle: pop shifts tail forward, push lands in first free slot.
            if (pop) begin
                if (tail_v_q) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = new_entry;
                    end else begin
                        tail_v_d = 1'b0;
                    end
                end else if (push) begin
                    head_d = new_entry;
                end else begin
                    head_v_d = 1'b0;
                end
            end else if (push) begin
                if (!head_v_q) begin
                    head_d   = new_entry;
                    head_v_d = 1'b1;
                end else begin
                    tail_d   = new_entry;
                    tail_v_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q          <= resetPC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            head_v_q      <= 1'b0;
            tail_v_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            head_v_q      <= head_v_d;
            tail_v_q      <= tail_v_d;
        end
    end

    assign memAddress = pc_q;
    assign instrOut   = head_q.instr;
    assign instrPC    = head_q.pc;
    assign instrValid = head_v_q;

    // The issue credit must make a push into a full buffer impossible.
    overflow_chk: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && head_v_q && tail_v_q));

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a sequential-fetch model pushes expected
// (PC, word) pairs and they are popped on each decode handshake.
module tb_instruction_fetch;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [7:0]  memAddress;
    logic [15:0] memData;
    logic [15:0] instrOut;
    logic [7:0]  instrPC;
    logic        instrValid;
    logic        instrReady;
    logic        redirect;
    logic [7:0]  redirectPC;
    logic        halt;

    logic [7:0]  mem_address2;
    logic [15:0] mem_data2;
    logic [15:0] instr_out2;
    logic [7:0]  instr_pc2;
    logic        instr_valid2;

    logic [15:0] mem [256];
    exp_t        sb[$];
    int          n_checks;
    int          n_fail;

    instruction_fetch #(.dataWidth(16), .addrWidth(8), .resetPC(8'h00)) dut (
        .clk(clk), .resetn(resetn), .memAddress(memAddress), .memData(memData),
        .instrOut(instrOut), .instrPC(instrPC), .instrValid(instrValid),
        .instrReady(instrReady), .redirect(redirect), .redirectPC(redirectPC), .halt(halt)
    );

    instruction_fetch #(.dataWidth(16), .addrWidth(8), .resetPC(8'hFE)) dut_wrap (
        .clk(clk), .resetn(resetn), .memAddress(mem_address2), .memData(mem_data2),
        .instrOut(instr_out2), .instrPC(instr_pc2), .instrValid(instr_valid2),
        .instrReady(instrReady), .redirect(redirect), .redirectPC(redirectPC), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-cycle-latency RAM models, mem[i] = 0x1000 + i
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    always @(posedge clk) begin
        memData   <= mem[memAddress];
        mem_data2 <= mem[mem_address2];
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        resetn     = 1'b0;
        instrReady = rdy;
        redirect   = 1'b0;
        halt       = 1'b0;
        redirectPC = 8'h00;
        step();
        step();
        sb.delete();
        resetn = 1'b1;
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 8'(i);
            e.instr = 16'h1000 + 16'(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1; instrReady = 1'b0; redirect = 1'b0; halt = 1'b0; redirectPC = 8'h00;
        #1 resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", instrValid); end
        n_checks++;
        if (instrOut !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instrOut); end
        n_checks++;
        if (instrPC !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", instrPC); end
        n_checks++;
        if (memAddress !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", memAddress); end
        n_checks++;
        if (mem_address2 !== 8'hFE) begin n_fail++; $display("FAIL reset_addr_wrap: got %h expected fe", mem_address2); end
        n_checks++;
        if (instr_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_wrap: got %0b expected 0", instr_valid2); end
    endtask

    task automatic test_stream();
        exp_t e;
        int   cyc;
        do_reset(1'b1);
        push_seq(8'h00, 8);
        step();
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL stream_lat1: got %0b expected 0", instrValid); end
        n_checks++;
        if (memAddress !== 8'h01) begin n_fail++; $display("FAIL stream_addr1: got %h expected 01", memAddress); end
        step();
        n_checks++;
        if (instrValid !== 1'b1) begin n_fail++; $display("FAIL stream_lat2: got %0b expected 1", instrValid); end
        cyc = 0;
        while (sb.size() != 0 && cyc < 16) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL stream_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 8) begin n_fail++; $display("FAIL stream_cycles: got %0d expected 8", cyc); end
    endtask

    task automatic test_stall();
        exp_t e;
        int   cyc;
        do_reset(1'b0);
        push_seq(8'h00, 6);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            e = sb[0];
            n_checks++;
            if (instrValid !== 1'b1 || instrPC !== e.pc || instrOut !== e.instr) begin
                n_fail++; $display("FAIL stall_head: got (%0b,%h,%h) expected (1,%h,%h)", instrValid, instrPC, instrOut, e.pc, e.instr);
            end
            step();
        end
        n_checks++;
        if (memAddress !== 8'h02) begin n_fail++; $display("FAIL stall_addr: got %h expected 02", memAddress); end
        instrReady = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 16) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL stall_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 6) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 6", cyc); end
    endtask

    task automatic test_redirect();
        exp_t e;
        int   cyc;
        // Redirect during a full-rate stream
        do_reset(1'b1);
        push_seq(8'h00, 3);
        step();
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL redir_pre_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        redirect = 1'b1; redirectPC = 8'h40;
        step();
        redirect = 1'b0;
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %0b expected 0", instrValid); end
        n_checks++;
        if (memAddress !== 8'h40) begin n_fail++; $display("FAIL redir_addr: got %h expected 40", memAddress); end
        push_seq(8'h40, 3);
        step();
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL redir_lat1: got %0b expected 0", instrValid); end
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL redir_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL redir_cycles: got %0d expected 3", cyc); end

        // Redirect with a full buffer, landing at the top of the address space
        do_reset(1'b0);
        step();
        step();
        step();
        redirect = 1'b1; redirectPC = 8'hFF;
        step();
        redirect = 1'b0; instrReady = 1'b1;
        n_checks++;
        if (instrValid !== 1'b0 || memAddress !== 8'hFF) begin
            n_fail++; $display("FAIL redir_full_flush: got (%0b,%h) expected (0,ff)", instrValid, memAddress);
        end
        push_seq(8'hFF, 3);
        step();
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL redir_full_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL redir_full_cycles: got %0d expected 3", cyc); end
    endtask

    task automatic test_redirect_halt();
        exp_t e;
        int   cyc;
        do_reset(1'b1);
        step();
        step();
        halt = 1'b1; redirect = 1'b1; redirectPC = 8'h80;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (instrValid !== 1'b0 || memAddress !== 8'h80) begin
                n_fail++; $display("FAIL rh_hold: got (%0b,%h) expected (0,80)", instrValid, memAddress);
            end
            step();
        end
        halt = 1'b0;
        push_seq(8'h80, 2);
        step();
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL rh_lat1: got %0b expected 0", instrValid); end
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL rh_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL rh_cycles: got %0d expected 2", cyc); end
    endtask

    task automatic test_halt();
        exp_t e;
        int   cyc;
        do_reset(1'b1);
        push_seq(8'h00, 3);
        step();
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL halt_pre_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        halt = 1'b1;
        push_seq(8'h03, 2);
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL halt_drain_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL halt_drain_cycles: got %0d expected 2", cyc); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (instrValid !== 1'b0 || memAddress !== 8'h05) begin
                n_fail++; $display("FAIL halt_idle: got (%0b,%h) expected (0,05)", instrValid, memAddress);
            end
            step();
        end
        halt = 1'b0;
        push_seq(8'h05, 3);
        step();
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL halt_resume_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL halt_resume_cycles: got %0d expected 3", cyc); end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   cyc;
        do_reset(1'b1);
        push_seq(8'hFE, 4);
        step();
        n_checks++;
        if (instr_valid2 !== 1'b0) begin n_fail++; $display("FAIL wrap_lat1: got %0b expected 0", instr_valid2); end
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instr_valid2 && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instr_pc2 !== e.pc || instr_out2 !== e.instr) begin
                    n_fail++; $display("FAIL wrap_word: got (%h,%h) expected (%h,%h)", instr_pc2, instr_out2, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL wrap_cycles: got %0d expected 4", cyc); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        do_reset(1'b1);
        step();
        step();
        step();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (instrValid !== 1'b0 || instrOut !== 16'h0000 || instrPC !== 8'h00 || memAddress !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_clear: got (%0b,%h,%h,%h) expected (0,0000,00,00)", instrValid, instrOut, instrPC, memAddress);
        end
        @(negedge clk);
        resetn = 1'b1;
        push_seq(8'h00, 3);
        step();
        n_checks++;
        if (instrValid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: got %0b expected 0", instrValid); end
        step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 8) begin
            if (instrValid && instrReady) begin
                e = sb.pop_front();
                n_checks++;
                if (instrPC !== e.pc || instrOut !== e.instr) begin
                    n_fail++; $display("FAIL mid_word: got (%h,%h) expected (%h,%h)", instrPC, instrOut, e.pc, e.instr);
                end
            end
            cyc++;
            step();
        end
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL mid_cycles: got %0d expected 3", cyc); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_halt();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
